// File: rtl/out_fifo.sv
// rtl/out_fifo.sv - serial-in, word-out FIFO with occupancy and error status
module out_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  inClock,
    input  logic                  inReset,
    input  logic                  inReadEnable,
    input  logic                  inWriteEnable,
    input  logic                  inData,
    output logic [ADDR_WIDTH:0]   outWriteCount,
    output logic [ADDR_WIDTH:0]   outReadCount,
    output logic                  outReadError,
    output logic                  outWriteError,
    output logic                  outFull,
    output logic                  outEmpty,
    output logic                  outAlmostEmpty,
    output logic                  outAlmostFull,
    output logic                  outDone,
    output logic [DATA_WIDTH-1:0] outData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0]       LAST_BIT        = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]       CNT_ONE         = CW'(1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE         = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] OCC_FULL        = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] OCC_ALMOST_FULL = {1'b0, {ADDR_WIDTH{1'b1}}};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wptr;
    logic [ADDR_WIDTH:0]   rptr;
    logic [ADDR_WIDTH:0]   occupancy;
    logic [CW-1:0]         bit_cnt;
    // The oldest bit falls off the top before it could ever be observed, so
    // only the low DATA_WIDTH-1 bits of the shift register are kept.
    logic [DATA_WIDTH-2:0] shift;

    logic [DATA_WIDTH-1:0] word;
    logic                  word_ready;
    logic                  full;
    logic                  empty;
    logic                  pop_ok;
    logic                  push_ok;

    assign occupancy  = wptr - rptr;
    assign full       = (occupancy == OCC_FULL);
    assign empty      = (wptr == rptr);
    assign word       = {shift, inData};
    assign word_ready = inWriteEnable && (bit_cnt == LAST_BIT);
    assign pop_ok     = inReadEnable && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still take the word.
    assign push_ok    = word_ready && (!full || pop_ok);

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            shift   <= '0;
            bit_cnt <= '0;
        end else if (inWriteEnable) begin
            shift   <= word[DATA_WIDTH-2:0];
            bit_cnt <= word_ready ? '0 : bit_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge inClock) begin
        if (push_ok) begin
            mem[wptr[ADDR_WIDTH-1:0]] <= word;
        end
    end

    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            wptr          <= '0;
            rptr          <= '0;
            outData       <= '0;
            outDone       <= 1'b0;
            outWriteError <= 1'b0;
            outReadError  <= 1'b0;
        end else begin
            outDone       <= push_ok;
            outWriteError <= word_ready && !push_ok;
            outReadError  <= inReadEnable && empty;
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop_ok) begin
                outData <= mem[rptr[ADDR_WIDTH-1:0]];
                rptr    <= rptr + PTR_ONE;
            end
        end
    end

    assign outWriteCount  = wptr;
    assign outReadCount   = rptr;
    assign outFull        = full;
    assign outEmpty       = empty;
    assign outAlmostEmpty = (occupancy <= PTR_ONE);
    assign outAlmostFull  = (occupancy >= OCC_ALMOST_FULL);

endmodule

// File: tb/tb_out_fifo.sv
// tb/tb_out_fifo.sv - directed self-checking bench for out_fifo
module tb_out_fifo;

    logic       inClock = 1'b0;
    logic       inReset = 1'b0;
    logic       inReadEnable = 1'b0;
    logic       inWriteEnable = 1'b0;
    logic       inData = 1'b0;
    logic [2:0] outWriteCount;
    logic [2:0] outReadCount;
    logic       outReadError;
    logic       outWriteError;
    logic       outFull;
    logic       outEmpty;
    logic       outAlmostEmpty;
    logic       outAlmostFull;
    logic       outDone;
    logic [3:0] outData;

    int total = 0;
    int bad   = 0;

    out_fifo #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inReadEnable   (inReadEnable),
        .inWriteEnable  (inWriteEnable),
        .inData         (inData),
        .outWriteCount  (outWriteCount),
        .outReadCount   (outReadCount),
        .outReadError   (outReadError),
        .outWriteError  (outWriteError),
        .outFull        (outFull),
        .outEmpty       (outEmpty),
        .outAlmostEmpty (outAlmostEmpty),
        .outAlmostFull  (outAlmostFull),
        .outDone        (outDone),
        .outData        (outData)
    );

    always #5 inClock = ~inClock;

    // Strobes four bits MSB first; optional pop on the last bit's edge.
    task automatic push_word(input logic [3:0] w, input logic re_last,
                             output logic done_s, output logic werr_s, output logic rerr_s);
        for (int i = 3; i >= 0; i--) begin
            inWriteEnable = 1'b1;
            inData        = w[i];
            inReadEnable  = (i == 0) ? re_last : 1'b0;
            @(posedge inClock);
            #1;
        end
        done_s        = outDone;
        werr_s        = outWriteError;
        rerr_s        = outReadError;
        inWriteEnable = 1'b0;
        inReadEnable  = 1'b0;
    endtask

    task automatic pop(output logic rerr_s);
        inReadEnable = 1'b1;
        @(posedge inClock);
        #1;
        rerr_s       = outReadError;
        inReadEnable = 1'b0;
    endtask

    task automatic idle();
        @(posedge inClock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge inClock);
        inReset = 1'b1;
        #1;
        total++;
        if ({outWriteCount, outReadCount, outData} !== 10'd0) begin
            bad++;
            $display("FAIL reset_regs: got w=%0d r=%0d d=%h want 0 0 0", outWriteCount, outReadCount, outData);
        end
        total++;
        if ({outEmpty, outAlmostEmpty, outFull, outAlmostFull, outDone, outReadError, outWriteError} !== 7'b1100000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1100000",
                     {outEmpty, outAlmostEmpty, outFull, outAlmostFull, outDone, outReadError, outWriteError});
        end
        @(negedge inClock);
        inReset = 1'b0;
        #1;
    endtask

    task automatic test_first_word();
        logic [3:0] bits = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            inWriteEnable = 1'b1;
            inData        = bits[i];
            @(posedge inClock);
            #1;
            if (i != 0) begin
                total++;
                if (outDone !== 1'b0 || outWriteCount !== 3'd0) begin
                    bad++;
                    $display("FAIL first_partial bit%0d: done=%b w=%0d want 0 0", i, outDone, outWriteCount);
                end
            end
        end
        inWriteEnable = 1'b0;
        total++;
        if ({outDone, outWriteCount, outEmpty, outAlmostEmpty} !== {1'b1, 3'd1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL first_push: done=%b w=%0d empty=%b aempty=%b want 1 1 0 1",
                     outDone, outWriteCount, outEmpty, outAlmostEmpty);
        end
        idle();
        total++;
        if (outDone !== 1'b0) begin
            bad++;
            $display("FAIL first_done_pulse: got %b want 0", outDone);
        end
    endtask

    task automatic test_fill();
        logic [3:0] vals [3] = '{4'hD, 4'h7, 4'hF};
        logic       d, we, re;
        for (int k = 0; k < 3; k++) begin
            push_word(vals[k], 1'b0, d, we, re);
            total++;
            if ({d, we, outWriteCount} !== {1'b1, 1'b0, 3'(k + 2)}) begin
                bad++;
                $display("FAIL fill_push%0d: done=%b werr=%b w=%0d want 1 0 %0d", k, d, we, outWriteCount, k + 2);
            end
            total++;
            if ({outAlmostFull, outFull} !== {(k >= 1), (k == 2)}) begin
                bad++;
                $display("FAIL fill_flags%0d: afull=%b full=%b want %b %b", k, outAlmostFull, outFull, k >= 1, k == 2);
            end
        end
    endtask

    task automatic test_overflow();
        logic d, we, re;
        push_word(4'h5, 1'b0, d, we, re);
        total++;
        if ({d, we, outWriteCount, outFull} !== {1'b0, 1'b1, 3'd4, 1'b1}) begin
            bad++;
            $display("FAIL overflow: done=%b werr=%b w=%0d full=%b want 0 1 4 1", d, we, outWriteCount, outFull);
        end
        idle();
        total++;
        if (outWriteError !== 1'b0) begin
            bad++;
            $display("FAIL overflow_pulse: werr=%b want 0", outWriteError);
        end
    endtask

    task automatic test_drain();
        logic [3:0] exp [4] = '{4'hA, 4'hD, 4'h7, 4'hF};
        logic       re;
        for (int k = 0; k < 4; k++) begin
            pop(re);
            total++;
            if ({re, outData, outReadCount} !== {1'b0, exp[k], 3'(k + 1)}) begin
                bad++;
                $display("FAIL drain%0d: rerr=%b data=%h r=%0d want 0 %h %0d", k, re, outData, outReadCount, exp[k], k + 1);
            end
        end
        total++;
        if ({outEmpty, outAlmostEmpty, outAlmostFull} !== 3'b110) begin
            bad++;
            $display("FAIL drain_flags: empty=%b aempty=%b afull=%b want 1 1 0", outEmpty, outAlmostEmpty, outAlmostFull);
        end
        pop(re);
        total++;
        if ({re, outData, outReadCount} !== {1'b1, 4'hF, 3'd4}) begin
            bad++;
            $display("FAIL underflow: rerr=%b data=%h r=%0d want 1 f 4", re, outData, outReadCount);
        end
        idle();
        total++;
        if (outReadError !== 1'b0) begin
            bad++;
            $display("FAIL underflow_pulse: rerr=%b want 0", outReadError);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] vals [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
        logic       d, we, re;
        for (int k = 0; k < 6; k++) begin
            push_word(vals[k], 1'b0, d, we, re);
            total++;
            if ({d, outWriteCount, outEmpty} !== {1'b1, 3'((5 + k) % 8), 1'b0}) begin
                bad++;
                $display("FAIL wrap_push%0d: done=%b w=%0d empty=%b want 1 %0d 0", k, d, outWriteCount, outEmpty, (5 + k) % 8);
            end
            pop(re);
            total++;
            if ({re, outData, outReadCount, outEmpty} !== {1'b0, vals[k], 3'((5 + k) % 8), 1'b1}) begin
                bad++;
                $display("FAIL wrap_pop%0d: rerr=%b data=%h r=%0d empty=%b want 0 %h %0d 1",
                         k, re, outData, outReadCount, outEmpty, vals[k], (5 + k) % 8);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vals [4] = '{4'h8, 4'h9, 4'hA, 4'hB};
        logic [3:0] exp  [4] = '{4'h9, 4'hA, 4'hB, 4'hC};
        logic       d, we, re;
        for (int k = 0; k < 4; k++) push_word(vals[k], 1'b0, d, we, re);
        total++;
        if ({outFull, outWriteCount} !== {1'b1, 3'd6}) begin
            bad++;
            $display("FAIL b2b_fill: full=%b w=%0d want 1 6", outFull, outWriteCount);
        end
        push_word(4'hC, 1'b1, d, we, re);
        total++;
        if ({d, we, re, outData, outWriteCount, outReadCount, outFull} !== {3'b100, 4'h8, 3'd7, 3'd3, 1'b1}) begin
            bad++;
            $display("FAIL b2b_simul: done=%b werr=%b rerr=%b data=%h w=%0d r=%0d full=%b want 1 0 0 8 7 3 1",
                     d, we, re, outData, outWriteCount, outReadCount, outFull);
        end
        for (int k = 0; k < 4; k++) begin
            pop(re);
            total++;
            if ({re, outData} !== {1'b0, exp[k]}) begin
                bad++;
                $display("FAIL b2b_drain%0d: rerr=%b data=%h want 0 %h", k, re, outData, exp[k]);
            end
        end
        total++;
        if ({outEmpty, outReadCount} !== {1'b1, 3'd7}) begin
            bad++;
            $display("FAIL b2b_empty: empty=%b r=%0d want 1 7", outEmpty, outReadCount);
        end
    endtask

    task automatic test_reset_midword();
        logic d, we, re;
        inWriteEnable = 1'b1;
        inData = 1'b1; @(posedge inClock); #1;
        inData = 1'b0; @(posedge inClock); #1;
        inWriteEnable = 1'b0;
        #2;
        inReset = 1'b1;
        #1;
        total++;
        if ({outData, outWriteCount, outReadCount, outEmpty} !== {4'h0, 3'd0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: data=%h w=%0d r=%0d empty=%b want 0 0 0 1", outData, outWriteCount, outReadCount, outEmpty);
        end
        @(negedge inClock);
        inReset = 1'b0;
        #1;
        push_word(4'hC, 1'b0, d, we, re);
        total++;
        if ({d, outWriteCount} !== {1'b1, 3'd1}) begin
            bad++;
            $display("FAIL midword_push: done=%b w=%0d want 1 1", d, outWriteCount);
        end
        pop(re);
        total++;
        if ({re, outData, outEmpty} !== {1'b0, 4'hC, 1'b1}) begin
            bad++;
            $display("FAIL midword_pop: rerr=%b data=%h empty=%b want 0 c 1", re, outData, outEmpty);
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_reset_midword();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/out_fifo.md
# out_fifo

Serial-in, word-out FIFO. It shifts single data bits into a DATA_WIDTH-bit word and pushes each completed word into a 2^ADDR_WIDTH-deep buffer. Words are popped in parallel on read request. It sits at the output of a bit-serial receive/decode chain, buffering assembled symbols (nibbles by default) for a downstream word-oriented consumer, and reports occupancy, full/empty and error status.

## Interface

Parameters:
- DATA_WIDTH, 4: bits per assembled word.
- ADDR_WIDTH, 2: address bits; depth = 2^ADDR_WIDTH (4).

Ports:
- inClock, input, 1: single clock; all state changes on the rising edge.
- inReset, input, 1: asynchronous, active-high reset.
- inReadEnable, input, 1: pop request, sampled each rising edge.
- inWriteEnable, input, 1: serial bit strobe; inData is sampled when it is high.
- inData, input, 1: serial data bit, MSB of each word first.
- outWriteCount, output, ADDR_WIDTH+1: write pointer, i.e. words pushed modulo 2^(ADDR_WIDTH+1).
- outReadCount, output, ADDR_WIDTH+1: read pointer, i.e. words popped modulo 2^(ADDR_WIDTH+1).
- outReadError, output, 1: one-cycle pulse when a read is requested while empty.
- outWriteError, output, 1: one-cycle pulse when a completed word is dropped because the FIFO is full.
- outFull, output, 1: occupancy == 2^ADDR_WIDTH.
- outEmpty, output, 1: occupancy == 0.
- outAlmostEmpty, output, 1: occupancy <= 1.
- outAlmostFull, output, 1: occupancy >= 2^ADDR_WIDTH − 1.
- outDone, output, 1: one-cycle pulse when a word is pushed into storage.
- outData, output, DATA_WIDTH: last popped word.

## Operation

- Deserializer: a DATA_WIDTH-bit shift register plus a bit counter (0..DATA_WIDTH−1).
  - On each edge with inWriteEnable=1: shift = {shift[DATA_WIDTH-2:0], inData} and increment the counter.
  - When the DATA_WIDTH-th bit is sampled, the completed word {shift[DATA_WIDTH-2:0], inData} is the push candidate and the counter returns to 0.
- Push: happens if the FIFO is not full, or if a pop is accepted in the same cycle.
  - mem[wptr[ADDR_WIDTH-1:0]] <= word; wptr increments; outDone pulses.
  - Otherwise the word is discarded, outWriteError pulses, and wptr is unchanged.
- Pop: on an edge with inReadEnable=1 and FIFO not empty:
  - outData <= mem[rptr[ADDR_WIDTH-1:0]]; rptr increments.
  - If inReadEnable=1 while empty: outReadError pulses; rptr and outData are unchanged.
- A simultaneous push and pop are both accepted; occupancy is unchanged.
- Occupancy = wptr − rptr, computed modulo 2^(ADDR_WIDTH+1).
  - Full: pointers equal except the MSB.
  - Empty: pointers equal.
- Pointers wrap naturally; storage index = pointer LSBs.
- Status flags are derived combinationally from the registered pointers.
- outData holds its value between pops.
- Reset (any time, including mid-word):
  - Pointers, bit counter, shift register and outData clear to 0.
  - Pulses are 0; outEmpty=1, outAlmostEmpty=1, outFull=0, outAlmostFull=0.
  - Storage contents need not be cleared.
  - A partially assembled word is lost.

## Timing

- Bit capture: 1 edge per strobe. There is no minimum gap between strobes; back-to-back strobes are legal.
- Word push latency: the word is stored on the same edge that samples its last bit.
  - outDone and outWriteError are high for exactly the following cycle.
  - outWriteCount and the flags update after that edge.
- Pop latency: outData is valid after the edge that accepts the read (1 cycle). outReadError is high for the following cycle.
- All outputs are synchronous except that the async reset forces them immediately to their reset values.

## Test plan

- Reset, then strobe bits 1,0,1,0 on four separate edges:
  - outDone pulses once after the 4th bit.
  - outWriteCount 0→1, outEmpty 1→0, outAlmostEmpty stays 1.
- Push nibbles A,D,7,F (bit sequences 1010, 1101, 0111, 1111):
  - outWriteCount=4, outFull=1, outAlmostFull=1 (first asserted at count 3).
- With the FIFO full, push a fifth nibble 0101:
  - outWriteError pulses, outDone stays 0, outWriteCount stays 4, contents are unchanged.
- Pop four times:
  - outData = 0xA, 0xD, 0x7, 0xF in order; outReadCount=4; outEmpty=1.
  - A fifth pop gives an outReadError pulse and outData stays 0xF.
- Pointer wrap: push and pop 6 words alternately.
  - Data order is preserved.
  - outWriteCount/outReadCount wrap 7→0; outEmpty is correct across the wrap.
- Assert inReset after 2 of 4 bits, release, then strobe 1,1,0,0:
  - Exactly one word 0xC is stored (earlier bits are discarded).
  - Pop returns 0xC.
